// File: rtl/dmem_arb_pkg.sv
// Shared types and access-size codes for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        CORE_PRI = 1'b0,
        DMA_PRI  = 1'b1
    } pri_state_e;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_CORE = 2'd1,
        PORT_DMA  = 2'd2
    } port_e;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

endpackage

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter in front of the single-port data memory: core priority with a
// DMA starvation guard, combinational grant, registered one-cycle read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [2:0]        c_mask,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              core_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_mask,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    pri_state_e        pri_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [DATA_W-1:0] rdata_q;
    port_e             rtag_q;
    logic              w_core_first;

    // The DMA can only win what the core did not take, so the grants never overlap.
    assign w_core_first = (pri_q == CORE_PRI);
    assign c_gnt        = c_req & (w_core_first | ~d_req);
    assign d_gnt        = d_req & ~c_gnt;
    assign core_stall   = c_req & ~c_gnt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_mask  = c_mask;
            mem_wr_en = c_we;
            mem_rd_en = ~c_we;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_mask  = d_mask;
            mem_wr_en = d_we;
            mem_rd_en = ~d_we;
        end
    end

    always_comb begin
        w_wait_nxt = '0;
        if (d_req && !d_gnt) begin
            w_wait_nxt = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q   <= CORE_PRI;
            wait_q  <= '0;
            rdata_q <= '0;
            rtag_q  <= PORT_NONE;
        end else begin
            wait_q <= w_wait_nxt;
            case (pri_q)
                CORE_PRI: if (w_wait_nxt == WAIT_MAX) pri_q <= DMA_PRI;
                DMA_PRI:  if (d_gnt || !d_req) pri_q <= CORE_PRI;
                default:  pri_q <= CORE_PRI;
            endcase
            rtag_q <= PORT_NONE;
            if (c_gnt && !c_we) begin
                rtag_q  <= PORT_CORE;
                rdata_q <= mem_rdata;
            end else if (d_gnt && !d_we) begin
                rtag_q  <= PORT_DMA;
                rdata_q <= mem_rdata;
            end
        end
    end

    assign c_rvalid = (rtag_q == PORT_CORE);
    assign d_rvalid = (rtag_q == PORT_DMA);
    assign c_rdata  = rdata_q;
    assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a read-return scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_mask, d_mask;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, core_stall;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mask;
    logic        mem_wr_en, mem_rd_en;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_core;
        logic [31:0] data;
        int          due;
    } rd_exp_t;
    rd_exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_mask     (c_mask),
        .c_gnt      (c_gnt),
        .c_rvalid   (c_rvalid),
        .c_rdata    (c_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_mask     (d_mask),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .core_stall (core_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: 64 little-endian words preloaded with C0DE_00xx, store on falling edge.
    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;
    logic [31:0] rd_word, rd_shift;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem_ready <= 1'b1;
        end else if (mem_wr_en) begin
            case (mem_mask)
                MASK_B, MASK_BU: mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8]  <= mem_wdata[7:0];
                MASK_H, MASK_HU: mem[mem_addr[7:2]][16*mem_addr[1] +: 16]  <= mem_wdata[15:0];
                default:         mem[mem_addr[7:2]]                        <= mem_wdata;
            endcase
        end
    end

    always_comb begin
        rd_word  = mem[mem_addr[7:2]];
        rd_shift = rd_word >> (8 * mem_addr[1:0]);
        case (mem_mask)
            MASK_B:  mem_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
            MASK_H:  mem_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
            MASK_BU: mem_rdata = {24'h0, rd_shift[7:0]};
            MASK_HU: mem_rdata = {16'h0, rd_shift[15:0]};
            default: mem_rdata = rd_word;
        endcase
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read-return monitor: every cycle out of reset, rvalid must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                check("c_rvalid", c_rvalid, sb[0].is_core);
                check("d_rvalid", d_rvalid, !sb[0].is_core);
                check(sb[0].is_core ? "c_rdata" : "d_rdata",
                      sb[0].is_core ? c_rdata : d_rdata, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("c_rvalid_idle", c_rvalid, 1'b0);
                check("d_rvalid_idle", d_rvalid, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_c(bit req, bit we, logic [31:0] a, logic [31:0] wd, logic [2:0] m);
        c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_mask = m;
    endtask

    task automatic drive_d(bit req, bit we, logic [31:0] a, logic [31:0] wd, logic [2:0] m);
        d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_mask = m;
    endtask

    // Checks the grant cycle against which port should win and queues the expected load data.
    task automatic cyc_check(string tag, bit ecg, bit edg, logic [31:0] eload);
        logic        ewr, erd;
        logic [31:0] ea, ewd;
        logic [2:0]  em;
        ewr = 1'b0; erd = 1'b0; ea = '0; ewd = '0; em = '0;
        if (ecg) begin
            ewr = c_we; erd = ~c_we; ea = c_addr; ewd = c_wdata; em = c_mask;
        end else if (edg) begin
            ewr = d_we; erd = ~d_we; ea = d_addr; ewd = d_wdata; em = d_mask;
        end
        check({tag, "_c_gnt"}, c_gnt, ecg);
        check({tag, "_d_gnt"}, d_gnt, edg);
        check({tag, "_stall"}, core_stall, c_req & ~ecg);
        check({tag, "_addr"}, mem_addr, ea);
        check({tag, "_wdata"}, mem_wdata, ewd);
        check({tag, "_mask"}, mem_mask, em);
        check({tag, "_wr_en"}, mem_wr_en, ewr);
        check({tag, "_rd_en"}, mem_rd_en, erd);
        check({tag, "_overlap"}, mem_wr_en & mem_rd_en, 1'b0);
        if ((ecg && !c_we) || (edg && !d_we))
            sb.push_back('{is_core: ecg, data: eload, due: cyc + 1});
    endtask

    task automatic step(string tag, bit ecg, bit edg, logic [31:0] eload);
        settle();
        cyc_check(tag, ecg, edg, eload);
        tick();
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_c_rvalid"}, c_rvalid, 1'b0);
        check({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        check({tag, "_rdata"}, c_rdata, 32'h0);
        check({tag, "_pri"}, dut.pri_q, CORE_PRI);
        check({tag, "_wait"}, 32'(dut.wait_q), 32'h0);
        check({tag, "_rd_en"}, mem_rd_en, 1'b0);
        check({tag, "_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        int ci;
        drive_c(0, 0, 0, 0, MASK_W);
        drive_d(0, 0, 0, 0, MASK_W);
        rst_n = 1'b0;
        repeat (2) tick();
        settle();
        check_reset_state("rst");
        tick();
        rst_n = 1'b1;

        // Core alone: store then load a word.
        drive_c(1, 1, 32'h10, 32'hDEADBEEF, MASK_W); step("t1_st", 1, 0, 0);
        drive_c(1, 0, 32'h10, 32'h0, MASK_W);        step("t1_ld", 1, 0, 32'hDEADBEEF);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);         step("t1_idle", 0, 0, 0);

        // DMA alone: store word, then byte-unsigned load of the top byte.
        drive_d(1, 1, 32'h10, 32'hAABBCCDD, MASK_W); step("t2_st", 0, 1, 0);
        drive_d(1, 0, 32'h13, 32'h0, MASK_BU);       step("t2_ld", 0, 1, 32'h000000AA);
        drive_d(0, 0, 32'h0, 32'h0, MASK_W);         step("t2_idle", 0, 0, 0);

        // Contention: six core loads, DMA held from cycle 0 wins cycle 3.
        ci = 0;
        for (int k = 0; k < 7; k++) begin
            drive_c(1, 0, 32'h40 + 32'(4 * ci), 32'h0, MASK_W);
            drive_d(k <= 3, 0, 32'h20, 32'h0, MASK_W);
            if (k == 3) check("t3_pri_dma", dut.pri_q, DMA_PRI);
            step($sformatf("t3_k%0d", k), k != 3, k == 3,
                 (k == 3) ? 32'hC0DE0008 : 32'hC0DE0010 + 32'(ci));
            if (k != 3) ci++;
        end
        check("t3_pri_back", dut.pri_q, CORE_PRI);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);
        drive_d(0, 0, 32'h0, 32'h0, MASK_W);
        step("t3_idle", 0, 0, 0);

        // Simultaneous single requests in CORE_PRI.
        drive_c(1, 1, 32'h30, 32'h11223344, MASK_W);
        drive_d(1, 0, 32'h44, 32'h0, MASK_W);   step("t4_both", 1, 0, 0);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);    step("t4_dma", 0, 1, 32'hC0DE0011);
        drive_d(0, 0, 32'h0, 32'h0, MASK_W);
        drive_c(1, 0, 32'h30, 32'h0, MASK_W);   step("t4_rb", 1, 0, 32'h11223344);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);    step("t4_idle", 0, 0, 0);

        // DMA drops its request while in DMA_PRI.
        check("t5_pri0", dut.pri_q, CORE_PRI);
        for (int k = 0; k < 4; k++) begin
            drive_c(1, 0, 32'h48, 32'h0, MASK_W);
            drive_d(k < 3, 1, 32'h24, 32'h55, MASK_W);
            if (k == 3) begin
                check("t5_pri_dma", dut.pri_q, DMA_PRI);
                check("t5_wait_sat", 32'(dut.wait_q), 32'd3);
            end
            step($sformatf("t5_k%0d", k), 1, 0, 32'hC0DE0012);
        end
        check("t5_pri_core", dut.pri_q, CORE_PRI);
        check("t5_wait_clr", 32'(dut.wait_q), 32'h0);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);
        drive_d(0, 0, 32'h0, 32'h0, MASK_W);
        step("t5_idle", 0, 0, 0);

        // Reset the cycle after a load grant: the pending rvalid is dropped.
        drive_c(1, 0, 32'h10, 32'h0, MASK_W);
        step("t6_ld", 1, 0, 32'hAABBCCDD);
        rst_n = 1'b0;
        sb.delete();
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);
        settle();
        check_reset_state("t6_rst");
        tick();
        rst_n = 1'b1;
        drive_c(1, 0, 32'h10, 32'h0, MASK_W); step("t6_reld", 1, 0, 32'hAABBCCDD);
        drive_c(0, 0, 32'h0, 32'h0, MASK_W);  step("t6_idle", 0, 0, 0);
        settle();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. It shares the memory between the pipeline load/store unit (core port, priority) and a loader/debug DMA port, with a starvation guard, and returns registered read data with a valid pulse. It sits between the memory-access stage and the data memory; the core stalls whenever its request is not granted.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 3: consecutive ungranted DMA cycles before DMA gets priority; must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`, `d_req`  in  1  core / DMA access request.
- `c_we`, `d_we`  in  1  1 = store, 0 = load.
- `c_addr`, `d_addr`  in  ADDR_W  byte address.
- `c_wdata`, `d_wdata`  in  DATA_W  store data.
- `c_mask`, `d_mask`  in  3  access size code (funct3 encoding).
- `c_gnt`, `d_gnt`  out  1  request accepted this cycle (combinational).
- `c_rvalid`, `d_rvalid`  out  1  load data valid, one cycle after grant.
- `c_rdata`, `d_rdata`  out  DATA_W  load data.
- `core_stall`  out  1  `c_req & ~c_gnt`.
- `mem_addr`  out  ADDR_W  to memory.
- `mem_wdata`  out  DATA_W  to memory.
- `mem_mask`  out  3  to memory.
- `mem_wr_en`, `mem_rd_en`  out  1  to memory.
- `mem_rdata`  in  DATA_W  from memory, combinational read.

## Operation
- FSM state `pri_q`, with states CORE_PRI (reset) and DMA_PRI.
- CORE_PRI:
  - core wins if `c_req`; otherwise DMA wins if `d_req`.
- DMA_PRI:
  - DMA wins if `d_req`; otherwise core wins if `c_req`.
  - Returns to CORE_PRI after the first DMA grant, or when `d_req` is low.
- Starvation counter `wait_q`, width `$clog2(STARVE_LIMIT+1)`:
  - +1 per cycle with `d_req & ~d_gnt`, saturating at `STARVE_LIMIT`.
  - Cleared on `d_gnt` or when `d_req` is low.
  - CORE_PRI→DMA_PRI on the clock edge where `wait_q` reaches `STARVE_LIMIT`.
- Granted port drives `mem_addr`/`mem_wdata`/`mem_mask`.
  - `mem_wr_en = we`, `mem_rd_en = ~we`.
- With no grant: all `mem_*` outputs are 0 and both enables are 0.
- `mask` is forwarded unchanged; size decode and alignment are the memory's job.
- Requesters hold `req`/`we`/`addr`/`wdata`/`mask` stable until `gnt`. A request may be dropped only while ungranted.
- Read return:
  - On a load grant, the posedge ending that cycle captures `mem_rdata` into `rdata_q` and a port tag into `rtag_q`.
  - Next cycle, `rvalid` pulses for the tagged port for exactly one cycle.
  - Both `*_rdata` outputs show `rdata_q`; they are meaningful only with `rvalid`.
- Stores produce no `rvalid`.

## Timing
- Reset values:
  - `pri_q` = CORE_PRI, `wait_q` = 0, `rdata_q` = 0, `rtag_q` = none.
  - `c_rvalid` = `d_rvalid` = 0.
- Grant is same-cycle combinational from `req` and `pri_q`; there is no req→gnt register.
- Store commits on the falling edge inside the grant cycle, so 0 cycles of added latency.
- Load latency is 1 cycle (grant at N, `rvalid` at N+1).
- Back-to-back grants are allowed every cycle. A load at N and a grant at N+1 give `rvalid` at N+1 and N+2.
- Simultaneous requests: only one grant per cycle; the loser sees `gnt = 0`, and `core_stall` is high if the loser is the core.
- Counter saturates; it never wraps.
- Reset mid-operation: any pending `rvalid` is dropped and the FSM returns to CORE_PRI; memory contents are untouched.

## Structure
- Package `dmem_arb_pkg`:
  - `pri_state_e` {CORE_PRI, DMA_PRI}.
  - `port_e` {PORT_NONE, PORT_CORE, PORT_DMA}.
  - Mask constants `MASK_B=3'b000`, `MASK_H=3'b001`, `MASK_W=3'b010`, `MASK_BU=3'b100`, `MASK_HU=3'b101`.
- Flat module with no sub-module.
- The bench instantiates the existing data memory behind the `mem_*` ports.

## Test plan
- Core alone: store word `0xDEADBEEF` to 0x10, then load word from 0x10 → `c_gnt` high both cycles, `c_rvalid=1` with `c_rdata=0xDEADBEEF` one cycle after the load grant, `core_stall` always 0.
- DMA alone: byte-unsigned load (mask `3'b100`) from 0x13 after storing `0xAABBCCDD` at 0x10 → `d_rvalid=1`, `d_rdata=0x000000AA`.
- Contention: core issues 6 loads back-to-back while `d_req` is held from cycle 0 → DMA granted on cycle 3 (`STARVE_LIMIT`=3), `c_gnt=0` and `core_stall=1` that cycle, core resumes on cycle 4.
- Simultaneous single requests in CORE_PRI → core granted, DMA granted the next cycle, no overlap of `mem_wr_en` and `mem_rd_en`.
- DMA drops `d_req` while in DMA_PRI → FSM back to CORE_PRI, `wait_q=0`, core granted that cycle.
- Assert `rst_n` low the cycle after a load grant → `c_rvalid` stays 0, outputs at reset values, and a new load after release returns the correct data.
